// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: bubble encoding, opcode constants,
// fetch FSM encoding, IF/ID update selector and skid buffer payload.
package rv_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013; // addi x0,x0,0
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HELD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  // How the IF/ID register is updated at the next edge.
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_FETCH  = 2'd1,
    IFID_BUBBLE = 2'd2,
    IFID_SKID   = 2'd3
  } ifid_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } skid_entry_t;

  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic is_branch(input logic [31:0] instr);
    return instr[6:0] == OPC_BRANCH;
  endfunction

  function automatic logic is_load(input logic [31:0] instr);
    return instr[6:0] == OPC_LOAD;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer: catches an instruction returned while IF/ID is
// stalled so the memory response is never lost.
module fetch_skid_buf
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  skid_entry_t din,
  output skid_entry_t dout,
  output logic        valid
);

  // Occupancy flag: clear (or reset) empties, load fills.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload register, captured on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives instruction-memory requests, fills the
// IF/ID register, absorbs ID stalls via a skid entry and handles redirects
// from ID, including dropping a response that is still in flight.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  fetch_stage_if.master        imem,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc,
  output logic                 if_id_valid,
  output logic [31:0]          stall_cnt
);
  import rv_pkg::*;

  fetch_state_e state_q, state_d;
  ifid_op_e     ifid_op;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  disc_addr_q;
  logic         disc_ld;
  logic         skid_ld, skid_clr, skid_valid;
  skid_entry_t  skid_din, skid_dout;

  assign skid_din = '{instr: imem.imem_rdata, pc: pc_q};

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_ld),
    .clear (skid_clr),
    .din   (skid_din),
    .dout  (skid_dout),
    .valid (skid_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:    state_d = ST_FETCH;
      ST_FETCH: begin
        if (id_stall) begin
          if (imem.imem_ready) state_d = ST_HELD;
        end else if (branch_taken && !imem.imem_ready) begin
          state_d = ST_DISCARD;
        end
      end
      ST_HELD:    if (!id_stall) state_d = ST_FETCH;
      ST_DISCARD: if (imem.imem_ready) state_d = ST_FETCH;
      default:    state_d = ST_BOOT;
    endcase
  end

  // Memory request outputs and datapath controls for the current state.
  // A redirect that leaves a request outstanding moves pc to the target at
  // once, while disc_addr_q keeps the old address on the bus until the
  // memory answers; that answer is then thrown away.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;
    ifid_op        = IFID_HOLD;
    pc_d           = pc_q;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    disc_ld        = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (!id_stall && branch_taken) begin
          ifid_op = IFID_BUBBLE;
          pc_d    = branch_target;
        end
      end
      ST_FETCH: begin
        imem.imem_req = 1'b1;
        if (id_stall) begin
          if (imem.imem_ready) begin
            skid_ld = 1'b1;
            pc_d    = pc_incr(pc_q);
          end
        end else if (branch_taken) begin
          ifid_op  = IFID_BUBBLE;
          skid_clr = 1'b1;
          pc_d     = branch_target;
          disc_ld  = !imem.imem_ready;
        end else if (imem.imem_ready) begin
          ifid_op = IFID_FETCH;
          pc_d    = pc_incr(pc_q);
        end else begin
          ifid_op = IFID_BUBBLE;
        end
      end
      ST_HELD: begin
        if (!id_stall) begin
          skid_clr = 1'b1;
          if (branch_taken) begin
            ifid_op = IFID_BUBBLE;
            pc_d    = branch_target;
          end else begin
            ifid_op = skid_valid ? IFID_SKID : IFID_BUBBLE;
          end
        end
      end
      ST_DISCARD: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = disc_addr_q;
        if (!id_stall) begin
          ifid_op = IFID_BUBBLE;
          if (branch_taken) pc_d = branch_target;
        end
      end
      default: ;
    endcase
  end

  // PC, outstanding-discard address and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      disc_addr_q <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= RESET_PC;
      if_id_valid <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (disc_ld) disc_addr_q <= pc_q;
      case (ifid_op)
        IFID_FETCH: begin
          if_id_instr <= imem.imem_rdata;
          if_id_pc    <= pc_q;
          if_id_valid <= 1'b1;
        end
        IFID_BUBBLE: begin
          if_id_instr <= NOP_INSTR;
          if_id_pc    <= pc_q;
          if_id_valid <= 1'b0;
        end
        IFID_SKID: begin
          if_id_instr <= skid_dout.instr;
          if_id_pc    <= skid_dout.pc;
          if_id_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (id_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a directed vector table plus a
// random-ready streaming sequence, both checked through a scoreboard queue.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        rdy = 1'b0;
  logic [31:0] if_id_instr, if_id_pc, stall_cnt;
  logic        if_id_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned step_no = 0;

  fetch_stage_if imem ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hC5, a[23:0]};
  endfunction

  assign imem.imem_ready = rdy;
  assign imem.imem_rdata = mem_word(imem.imem_addr);

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_stall      (id_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, s, b;
    logic [31:0] t;
    logic        y;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[$];

  function automatic vec_t mk(input logic r, s, b, input logic [31:0] t,
                              input logic y, input logic er,
                              input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ec);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.t = t; v.y = y;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_cnt = ec;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, step_no, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // pop and compare them just after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.r; id_stall = v.s; branch_taken = v.b; branch_target = v.t;
    rdy = v.y;
    e.e_req   = v.e_req;
    e.e_addr  = v.e_addr;
    e.e_valid = v.e_valid;
    e.e_pc    = v.e_pc;
    e.e_instr = v.e_valid ? mem_word(v.e_pc) : 32'h0000_0013;
    e.e_cnt   = v.e_cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    cmp("imem_req", {31'b0, imem.imem_req}, {31'b0, e.e_req});
    if (e.e_req) cmp("imem_addr", imem.imem_addr, e.e_addr);
    cmp("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.e_valid});
    cmp("if_id_pc", if_id_pc, e.e_pc);
    cmp("if_id_instr", if_id_instr, e.e_instr);
    cmp("stall_cnt", stall_cnt, e.e_cnt);
    step_no++;
  endtask

  initial begin
    logic [31:0] np;
    logic        y;
    int unsigned nready;
    int unsigned nvalid_edges;

    //               rst stl br  target         rdy req addr           vld if_id_pc       cnt
    // boot and streaming fetch
    vt.push_back(mk(1, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0,   32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0,   32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h8,   1, 32'h4,   32'd0));
    // three stalled cycles, the pc=8 word goes to the skid
    vt.push_back(mk(0, 1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h4,   32'd1));
    vt.push_back(mk(0, 1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h4,   32'd2));
    vt.push_back(mk(0, 1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h4,   32'd3));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 1, 32'hC,   1, 32'h8,   32'd3));
    // redirect with data returned in the same cycle
    vt.push_back(mk(0, 0, 1, 32'h100, 1, 1, 32'h100, 0, 32'hC,   32'd3));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h104, 1, 32'h100, 32'd3));
    // reset, fetch up to 0x10, redirect while 0x10 is still pending
    vt.push_back(mk(1, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 1, 32'h0,   0, 32'h0,   32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0,   32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h8,   1, 32'h4,   32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'hC,   1, 32'h8,   32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h10,  1, 32'hC,   32'd0));
    vt.push_back(mk(0, 0, 1, 32'h200, 0, 1, 32'h10,  0, 32'h10,  32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 1, 32'h10,  0, 32'h200, 32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h200, 32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h204, 1, 32'h200, 32'd0));
    // enter HELD, then reset from HELD
    vt.push_back(mk(0, 1, 0, 32'h0,   1, 0, 32'h0,   1, 32'h200, 32'd1));
    vt.push_back(mk(1, 1, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0,   32'd0));
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 1, 32'h0,   0, 32'h0,   32'd0));
    vt.push_back(mk(0, 1, 0, 32'h0,   0, 1, 32'h0,   0, 32'h0,   32'd1));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0,   32'd1));
    // branch under stall is ignored
    vt.push_back(mk(0, 1, 1, 32'h300, 0, 1, 32'h4,   1, 32'h0,   32'd2));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h8,   1, 32'h4,   32'd2));
    // second redirect while discarding only moves pc
    vt.push_back(mk(0, 0, 1, 32'h400, 0, 1, 32'h8,   0, 32'h8,   32'd2));
    vt.push_back(mk(0, 0, 1, 32'h500, 0, 1, 32'h8,   0, 32'h400, 32'd2));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h500, 0, 32'h500, 32'd2));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h504, 1, 32'h500, 32'd2));
    // not-ready cycle in FETCH inserts a bubble, address held
    vt.push_back(mk(0, 0, 0, 32'h0,   0, 1, 32'h504, 0, 32'h504, 32'd2));
    vt.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h508, 1, 32'h504, 32'd2));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i]);
    end

    // Streaming with random memory latency: every ready cycle delivers the
    // next sequential word, every idle cycle a bubble at the same pc.
    step(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'd0));
    step(mk(0, 0, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 32'd0));
    np = 32'h0;
    nready = 0;
    nvalid_edges = 0;
    for (int i = 0; i < 60; i++) begin
      y = 1'($urandom_range(0, 1));
      if (y) begin
        step(mk(0, 0, 0, 32'h0, 1, 1, np + 32'd4, 1, np, 32'd0));
        np = np + 32'd4;
        nready++;
      end else begin
        step(mk(0, 0, 0, 32'h0, 0, 1, np, 0, np, 32'd0));
      end
      if (if_id_valid) nvalid_edges++;
    end
    cmp("stream_count", nvalid_edges, nready);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout step %0d: got running want finished", step_no);
    $fatal(1, "timeout");
  end

endmodule
